// File: rtl/vx_fpu_csr_state.sv
// Per-warp FPU CSR state (fflags/frm) with drained CSR access and pending-instruction tracking.
// Optional FPU_CSR_PERF_EN adds a DRAIN-cycle counter port, also readable at CSR 0xB1F.
module vx_fpu_csr_state #(
  parameter int NUM_WARPS  = 4,
  parameter int NUM_BLOCKS = 1,
  parameter int CNT_W      = 4,
  localparam int NW_W      = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_BLOCKS*NW_W-1:0] read_wid,
  output logic [NUM_BLOCKS*3-1:0]    read_frm,
  input  logic [NUM_BLOCKS-1:0]      issue_fire,
  input  logic [NUM_BLOCKS*NW_W-1:0] issue_wid,
  output logic [NUM_BLOCKS-1:0]      issue_stall,
  input  logic [NUM_BLOCKS-1:0]      rsp_done,
  input  logic [NUM_BLOCKS*NW_W-1:0] rsp_wid,
  input  logic [NUM_BLOCKS-1:0]      write_enable,
  input  logic [NUM_BLOCKS*NW_W-1:0] write_wid,
  input  logic [NUM_BLOCKS*5-1:0]    write_fflags,
  input  logic                       csr_req_valid,
  output logic                       csr_req_ready,
  input  logic [NW_W-1:0]            csr_req_wid,
  input  logic [11:0]                csr_req_addr,
  input  logic [1:0]                 csr_req_op,
  input  logic [31:0]                csr_req_data,
  output logic                       csr_rsp_valid,
  input  logic                       csr_rsp_ready,
  output logic [31:0]                csr_rsp_data
`ifdef FPU_CSR_PERF_EN
  , output logic [31:0]              perf_drain_cycles
`endif
);

  localparam int SW = CNT_W + $clog2(NUM_BLOCKS + 1) + 1;
  localparam logic [SW-1:0] PEND_MAX = SW'((1 << CNT_W) - 1);

  typedef enum logic [1:0] {IDLE, DRAIN, RESP} state_t;

  state_t           state;
  logic [4:0]       fflags  [NUM_WARPS];
  logic [2:0]       frm     [NUM_WARPS];
  logic [CNT_W-1:0] pending [NUM_WARPS];

  logic [SW-1:0]    inc_cnt  [NUM_WARPS];
  logic [SW-1:0]    dec_cnt  [NUM_WARPS];
  logic [SW-1:0]    pend_sum [NUM_WARPS];
  logic [SW-1:0]    pend_dif [NUM_WARPS];
  logic [CNT_W-1:0] pend_nxt [NUM_WARPS];
  logic             pend_under [NUM_WARPS];
  logic             pend_over  [NUM_WARPS];
  logic [4:0]       ff_wr  [NUM_WARPS];
  logic             wr_hit [NUM_WARPS];

  logic [NW_W-1:0]  req_wid;
  logic [11:0]      req_addr;
  logic [1:0]       req_op;
  logic [7:0]       req_data;
  logic [31:0]      old_val;
  logic [4:0]       new_ff;
  logic [2:0]       new_frm;
  logic [7:0]       new_fcsr;
  logic             drain_ok;
  logic             apply;
  logic             unused_data_hi;

  assign unused_data_hi = ^csr_req_data[31:8];

  function automatic logic [7:0] apply_op(input logic [1:0] op, input logic [7:0] old,
                                          input logic [7:0] d);
    case (op)
      2'd1:    return d;
      2'd2:    return old | d;
      2'd3:    return old & ~d;
      default: return old;
    endcase
  endfunction

  always_comb begin
    read_frm    = '0;
    issue_stall = '0;
    for (int unsigned b = 0; b < NUM_BLOCKS; b++) begin
      read_frm[b*3 +: 3] = frm[read_wid[b*NW_W +: NW_W]];
      issue_stall[b]     = (pending[issue_wid[b*NW_W +: NW_W]] == '1);
    end
  end

  // Net per-warp pending change and merged fflags from all blocks in one cycle
  always_comb begin
    for (int unsigned w = 0; w < NUM_WARPS; w++) begin
      inc_cnt[w] = '0;
      dec_cnt[w] = '0;
      ff_wr[w]   = '0;
      wr_hit[w]  = 1'b0;
      for (int unsigned b = 0; b < NUM_BLOCKS; b++) begin
        if (issue_fire[b] && issue_wid[b*NW_W +: NW_W] == NW_W'(w))
          inc_cnt[w] = inc_cnt[w] + 1'b1;
        if (rsp_done[b] && rsp_wid[b*NW_W +: NW_W] == NW_W'(w))
          dec_cnt[w] = dec_cnt[w] + 1'b1;
        if (write_enable[b] && write_wid[b*NW_W +: NW_W] == NW_W'(w)) begin
          ff_wr[w]  = ff_wr[w] | write_fflags[b*5 +: 5];
          wr_hit[w] = 1'b1;
        end
      end
      pend_sum[w]   = SW'(pending[w]) + inc_cnt[w];
      pend_dif[w]   = pend_sum[w] - dec_cnt[w];
      pend_under[w] = dec_cnt[w] > pend_sum[w];
      pend_over[w]  = !pend_under[w] && (pend_dif[w] > PEND_MAX);
      if (pend_under[w])     pend_nxt[w] = '0;
      else if (pend_over[w]) pend_nxt[w] = '1;
      else                   pend_nxt[w] = CNT_W'(pend_dif[w]);
    end
  end

  assign drain_ok = (pending[req_wid] == '0) && !wr_hit[req_wid];
  assign apply    = (state == DRAIN) && drain_ok;

  // Unknown addresses leave new_* at the current value, so the commit is a no-op
  always_comb begin
    old_val  = '0;
    new_ff   = fflags[req_wid];
    new_frm  = frm[req_wid];
    new_fcsr = '0;
    case (req_addr)
      12'h001: begin
        old_val = {27'd0, fflags[req_wid]};
        new_ff  = 5'(apply_op(req_op, {3'd0, fflags[req_wid]}, {3'd0, req_data[4:0]}));
      end
      12'h002: begin
        old_val = {29'd0, frm[req_wid]};
        new_frm = 3'(apply_op(req_op, {5'd0, frm[req_wid]}, {5'd0, req_data[2:0]}));
      end
      12'h003: begin
        old_val  = {24'd0, frm[req_wid], fflags[req_wid]};
        new_fcsr = apply_op(req_op, {frm[req_wid], fflags[req_wid]}, req_data);
        new_frm  = new_fcsr[7:5];
        new_ff   = new_fcsr[4:0];
      end
`ifdef FPU_CSR_PERF_EN
      12'hB1F: old_val = perf_drain_cycles;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned w = 0; w < NUM_WARPS; w++) begin
        fflags[w]  <= '0;
        frm[w]     <= '0;
        pending[w] <= '0;
      end
    end else begin
      for (int unsigned w = 0; w < NUM_WARPS; w++) begin
        pending[w] <= pend_nxt[w];
        fflags[w]  <= fflags[w] | ff_wr[w];
        if (apply && req_wid == NW_W'(w)) begin
          fflags[w] <= new_ff;
          frm[w]    <= new_frm;
        end
        assert (!pend_under[w]);
        assert (!pend_over[w]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      csr_req_ready <= 1'b1;
      csr_rsp_valid <= 1'b0;
      csr_rsp_data  <= '0;
      req_wid       <= '0;
      req_addr      <= '0;
      req_op        <= '0;
      req_data      <= '0;
    end else begin
      case (state)
        IDLE: if (csr_req_valid) begin
          req_wid       <= csr_req_wid;
          req_addr      <= csr_req_addr;
          req_op        <= csr_req_op;
          req_data      <= csr_req_data[7:0];
          csr_req_ready <= 1'b0;
          state         <= DRAIN;
        end
        DRAIN: if (drain_ok) begin
          csr_rsp_data  <= old_val;
          csr_rsp_valid <= 1'b1;
          state         <= RESP;
        end
        RESP: if (csr_rsp_ready) begin
          csr_rsp_valid <= 1'b0;
          csr_req_ready <= 1'b1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FPU_CSR_PERF_EN
  always_ff @(posedge clk) begin
    if (reset)               perf_drain_cycles <= '0;
    else if (state == DRAIN) perf_drain_cycles <= perf_drain_cycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_vx_fpu_csr_state.sv
// Directed bench for vx_fpu_csr_state with two FPU blocks and four warps.
module tb_vx_fpu_csr_state;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  read_wid, issue_wid, rsp_wid, write_wid;
  logic [5:0]  read_frm;
  logic [1:0]  issue_fire, issue_stall, rsp_done, write_enable;
  logic [9:0]  write_fflags;
  logic        csr_req_valid, csr_req_ready, csr_rsp_valid, csr_rsp_ready;
  logic [1:0]  csr_req_wid;
  logic [11:0] csr_req_addr;
  logic [1:0]  csr_req_op;
  logic [31:0] csr_req_data, csr_rsp_data;
`ifdef FPU_CSR_PERF_EN
  logic [31:0] perf_drain_cycles;
`endif

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] rd;
  int lat;

  vx_fpu_csr_state #(.NUM_WARPS(4), .NUM_BLOCKS(2), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .read_wid(read_wid), .read_frm(read_frm),
    .issue_fire(issue_fire), .issue_wid(issue_wid), .issue_stall(issue_stall),
    .rsp_done(rsp_done), .rsp_wid(rsp_wid),
    .write_enable(write_enable), .write_wid(write_wid), .write_fflags(write_fflags),
    .csr_req_valid(csr_req_valid), .csr_req_ready(csr_req_ready),
    .csr_req_wid(csr_req_wid), .csr_req_addr(csr_req_addr),
    .csr_req_op(csr_req_op), .csr_req_data(csr_req_data),
    .csr_rsp_valid(csr_rsp_valid), .csr_rsp_ready(csr_rsp_ready),
    .csr_rsp_data(csr_rsp_data)
`ifdef FPU_CSR_PERF_EN
    , .perf_drain_cycles(perf_drain_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic csr_fire(input logic [1:0] wid, input logic [11:0] addr,
                          input logic [1:0] op, input logic [31:0] data);
    chk("req_ready_idle", {31'd0, csr_req_ready}, 32'd1);
    csr_req_valid = 1'b1;
    csr_req_wid   = wid;
    csr_req_addr  = addr;
    csr_req_op    = op;
    csr_req_data  = data;
    tick();
    csr_req_valid = 1'b0;
  endtask

  // lat counts the fire cycle as 1, so the fastest response reports 2
  task automatic csr_op(input logic [1:0] wid, input logic [11:0] addr, input logic [1:0] op,
                        input logic [31:0] data, output logic [31:0] rdata, output int cyc);
    csr_fire(wid, addr, op, data);
    cyc = 1;
    while (!csr_rsp_valid && cyc < 40) begin
      tick();
      cyc++;
    end
    chk("rsp_valid", {31'd0, csr_rsp_valid}, 32'd1);
    rdata = csr_rsp_data;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    read_wid = '0; issue_wid = '0; rsp_wid = '0; write_wid = '0;
    issue_fire = '0; rsp_done = '0; write_enable = '0; write_fflags = '0;
    csr_req_valid = 1'b0; csr_req_wid = '0; csr_req_addr = '0; csr_req_op = '0;
    csr_req_data = '0; csr_rsp_ready = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    read_wid = {2'd1, 2'd0};
    #1;
    chk("rst_req_ready", {31'd0, csr_req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, csr_rsp_valid}, 32'd0);
    chk("rst_rsp_data", csr_rsp_data, 32'd0);
    chk("rst_read_frm", {26'd0, read_frm}, 32'd0);
    chk("rst_stall", {30'd0, issue_stall}, 32'd0);

    csr_op(2'd2, 12'h003, 2'd0, 32'd0, rd, lat);
    chk("rst_fcsr_w2", rd, 32'd0);
    chk("min_latency", lat, 2);

    // frm write to warp 1 becomes visible on read_frm once it commits
    read_wid = {2'd0, 2'd1};
    csr_fire(2'd1, 12'h002, 2'd1, 32'h1);
    chk("frm_pre_commit", {29'd0, read_frm[2:0]}, 32'd0);
    chk("frm_rsp_t1", {31'd0, csr_rsp_valid}, 32'd0);
    tick();
    chk("frm_rsp_t2", {31'd0, csr_rsp_valid}, 32'd1);
    chk("frm_old", csr_rsp_data, 32'd0);
    chk("frm_w1", {29'd0, read_frm[2:0]}, 32'd1);
    chk("frm_w0", {29'd0, read_frm[5:3]}, 32'd0);
    tick();

    // two blocks merge fflags into warp 0
    write_enable = 2'b11; write_wid = 4'b0000; write_fflags = {5'h10, 5'h01};
    tick();
    write_enable = '0;
    csr_op(2'd0, 12'h001, 2'd0, 32'd0, rd, lat);
    chk("fflags_merge", rd, 32'h11);

    // CSR read stalls until warp 3 drains
    issue_fire = 2'b01; issue_wid = {2'd0, 2'd3};
    repeat (2) tick();
    issue_fire = '0;
    csr_fire(2'd3, 12'h001, 2'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("drain_hold_valid", {31'd0, csr_rsp_valid}, 32'd0);
      chk("drain_hold_ready", {31'd0, csr_req_ready}, 32'd0);
    end
    rsp_done = 2'b01; rsp_wid = {2'd0, 2'd3};
    tick();
    rsp_done = '0;
    chk("drain_after_1done", {31'd0, csr_rsp_valid}, 32'd0);
    rsp_done = 2'b01; write_enable = 2'b10; write_wid = {2'd3, 2'd0};
    write_fflags = {5'h04, 5'h00};
    tick();
    rsp_done = '0; write_enable = '0;
    chk("drain_last_write", {31'd0, csr_rsp_valid}, 32'd0);
    tick();
    chk("drain_rsp_valid", {31'd0, csr_rsp_valid}, 32'd1);
    chk("drain_rsp_data", csr_rsp_data, 32'h04);
    tick();

    // pending saturation on warp 0; block 1 probes warp 1
    issue_fire = 2'b01; issue_wid = {2'd1, 2'd0};
    repeat (14) tick();
    chk("stall_at_14", {31'd0, issue_stall[0]}, 32'd0);
    tick();
    issue_fire = '0;
    #1;
    chk("stall_at_15", {31'd0, issue_stall[0]}, 32'd1);
    chk("stall_other_warp", {31'd0, issue_stall[1]}, 32'd0);
    issue_fire = 2'b01; rsp_done = 2'b01; rsp_wid = {2'd0, 2'd0};
    tick();
    issue_fire = '0; rsp_done = '0;
    #1;
    chk("pend_hold_15", {31'd0, issue_stall[0]}, 32'd1);
    rsp_done = 2'b01;
    tick();
    rsp_done = '0;
    #1;
    chk("stall_clear_14", {31'd0, issue_stall[0]}, 32'd0);
    rsp_done = 2'b01;
    repeat (14) tick();
    rsp_done = '0;
    csr_op(2'd0, 12'h001, 2'd0, 32'd0, rd, lat);
    chk("w0_drained_data", rd, 32'h11);
    chk("w0_drained_lat", lat, 2);

    // fcsr set then clear with a stalled response
    csr_op(2'd2, 12'h003, 2'd2, 32'hE0, rd, lat);
    chk("fcsr_set_old", rd, 32'd0);
    csr_rsp_ready = 1'b0;
    csr_fire(2'd2, 12'h003, 2'd3, 32'h80);
    tick();
    chk("clr_rsp_valid", {31'd0, csr_rsp_valid}, 32'd1);
    chk("clr_rsp_data", csr_rsp_data, 32'hE0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_valid", {31'd0, csr_rsp_valid}, 32'd1);
      chk("bp_data", csr_rsp_data, 32'hE0);
      chk("bp_req_ready", {31'd0, csr_req_ready}, 32'd0);
    end
    csr_rsp_ready = 1'b1;
    tick();
    chk("bp_release_valid", {31'd0, csr_rsp_valid}, 32'd0);
    chk("bp_release_ready", {31'd0, csr_req_ready}, 32'd1);
    read_wid = {2'd1, 2'd2};
    #1;
    chk("frm_w2_after_clr", {29'd0, read_frm[2:0]}, 32'd3);
    chk("frm_w1_kept", {29'd0, read_frm[5:3]}, 32'd1);
    csr_op(2'd2, 12'h003, 2'd0, 32'd0, rd, lat);
    chk("fcsr_w2", rd, 32'h60);

    // unknown addresses
    csr_op(2'd2, 12'h005, 2'd1, 32'hFF, rd, lat);
    chk("unk_addr_data", rd, 32'd0);
`ifndef FPU_CSR_PERF_EN
    csr_op(2'd2, 12'hB1F, 2'd0, 32'd0, rd, lat);
    chk("perf_addr_absent", rd, 32'd0);
`endif
    csr_op(2'd2, 12'h003, 2'd0, 32'd0, rd, lat);
    chk("unk_no_change", rd, 32'h60);

    // field-width truncation on fflags write
    csr_op(2'd1, 12'h001, 2'd1, 32'hFFFF_FFFF, rd, lat);
    chk("ff_write_old", rd, 32'd0);
    csr_op(2'd1, 12'h003, 2'd0, 32'd0, rd, lat);
    chk("fcsr_w1", rd, 32'h3F);

    // reset while draining drops the response and clears state
    issue_fire = 2'b01; issue_wid = {2'd0, 2'd1};
    tick();
    issue_fire = '0;
    csr_fire(2'd1, 12'h003, 2'd0, 32'd0);
    tick();
    chk("mid_drain_valid", {31'd0, csr_rsp_valid}, 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_valid", {31'd0, csr_rsp_valid}, 32'd0);
    chk("mid_rst_ready", {31'd0, csr_req_ready}, 32'd1);
    csr_op(2'd1, 12'h003, 2'd0, 32'd0, rd, lat);
    chk("mid_rst_fcsr", rd, 32'd0);
    chk("mid_rst_lat", lat, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
